pipe_field: RTL and testbench
=============================

# pipe_field

Scrolling playfield stage directly downstream of the pipe-pattern generator. Captures each one-cycle 15-bit pipe column pattern and holds it until the next scroll tick, then injects it at the right edge of a column shift register that the LED driver reads. Enforces a minimum gap of empty columns between pipes, detects bird/pipe collisions at the bird column, and counts pipes passed.

## Interface

Parameters:
- ROWS, 15, bits per column; matches the generator's pattern width.
- COLS, 16, number of display columns. Column COLS-1 is the right edge (entry); column 0 is the left edge (exit).
- BIRD_COL, 3, column index the bird occupies.
- GAP, 3, minimum number of empty columns inserted after every pipe column.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  scroll enable; one-cycle pulse.
- game_over  in  1  freezes scrolling, capture and scoring while high.
- pattern_in  in  ROWS  pipe column from the generator; nonzero for one cycle when a new pipe is offered, zero otherwise.
- bird_row  in  4  bird row index; 0 is the bottom row.
- col_sel  in  4  column index requested by the LED driver.
- col_data  out  ROWS  combinational contents of column col_sel; all zeros if col_sel >= COLS.
- collide  out  1  registered, sticky collision flag.
- score  out  7  pipes passed; saturates at 99.
- pending  out  1  a captured pipe is waiting for insertion.

## Operation

- Storage:
  - field: COLS x ROWS register array.
  - hold: ROWS-bit register for the captured pattern.
  - gap_cnt: counter sized to hold GAP.
- Insertion state machine, with states EMPTY, HELD and GAPPING:
  - EMPTY: a nonzero pattern_in with game_over low loads hold and moves to HELD.
  - HELD: nonzero pattern_in is ignored (dropped).
    - On tick, if gap_cnt == 0: inject hold at column COLS-1 and clear hold. Set gap_cnt = GAP and go to GAPPING; if GAP == 0, go to EMPTY instead.
    - On tick, if gap_cnt != 0: inject zeros and decrement gap_cnt.
  - GAPPING: each tick injects zeros and decrements gap_cnt.
    - When gap_cnt reaches 0, go to EMPTY.
    - A nonzero pattern_in arriving in GAPPING loads hold and moves to HELD; gap_cnt keeps counting.
  - A tick in EMPTY injects zeros.
- Scroll on tick with game_over low:
  - field[i] <= field[i+1] for i < COLS-1.
  - field[COLS-1] <= injected column.
  - field[0] is discarded.
- Simultaneous tick and nonzero pattern_in in EMPTY: inject zeros on this tick; capture the pattern into hold (state HELD). It is inserted no earlier than the following tick.
- Simultaneous tick and nonzero pattern_in in HELD with gap_cnt == 0: inject the old hold. The new pattern is dropped.
- Scoring: on a scroll, if the pre-shift field[BIRD_COL] is nonzero and collide is 0, increment score, saturating at 99.
- Collision:
  - Every cycle, collide <= collide | hit.
  - hit = (bird_row >= ROWS) or field[BIRD_COL][bird_row], using current register contents.
  - Evaluated regardless of tick.
  - Not evaluated while game_over is high.
- game_over high: field, hold, state, gap_cnt and score hold their values; tick and pattern_in are ignored. col_data stays readable.

## Timing

- Reset values: field all 0, hold 0, state EMPTY, gap_cnt 0, pending 0, collide 0, score 0.
- Reset has priority over tick, pattern_in and game_over; reset mid-scroll clears everything in one cycle.
- pending = (state == HELD), registered; rises the cycle after capture.
- Latencies:
  - Capture to earliest appearance at column COLS-1: the first tick strictly after the capture cycle. The column is visible on col_data the cycle after that tick.
  - A column injected on tick k reaches BIRD_COL after COLS-1-BIRD_COL further ticks.
  - collide asserts one cycle after the overlap exists in field/bird_row.
  - score updates the cycle after the scoring tick.
- col_data is purely combinational from col_sel and field; zero latency.

## Test plan

- Reset then capture: assert reset 1 cycle. pattern_in=15'b110000011111111 for 1 cycle, then a tick 3 cycles later -> pending=1 after capture; col_data(col_sel=15)=15'b110000011111111 the cycle after the tick; pending=0.
- Gap enforcement: capture P1 and tick; capture P2 immediately; issue 4 ticks -> columns 15..12 read P2,0,0,0 (P2 injected on the 4th tick); P1 at column 11.
- Drop and simultaneity: in HELD with gap_cnt=0, pulse tick and a new nonzero pattern in the same cycle -> old pattern injected, new dropped, state GAPPING; in EMPTY, tick plus pattern -> zeros injected, pending=1 next cycle.
- Collision and score: pipe 15'b111100000111111 scrolled to column 3, bird_row=2 -> score unchanged, collide=1 one cycle later and stays 1. Repeat with bird_row=8 -> collide=0; score=1 after the pipe leaves column 3. Test bird_row=15 -> collide=1.
- game_over freeze: assert game_over, pulse 5 ticks and 2 patterns -> field, score and pending unchanged; deassert and resume normally.
- Score saturation and reset mid-run: pass 101 pipes -> score=99; then assert reset during a tick -> all outputs zero the next cycle.

Source files
------------

// File: rtl/pipe_field.sv
// Scrolling pipe playfield: captures generator columns, enforces an empty-column gap
// between pipes, scrolls on tick, and tracks bird collisions and pipes passed.
module pipe_field #(
  parameter int ROWS     = 15,
  parameter int COLS     = 16,
  parameter int BIRD_COL = 3,
  parameter int GAP      = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            game_over,
  input  logic [ROWS-1:0] pattern_in,
  input  logic [3:0]      bird_row,
  input  logic [3:0]      col_sel,
  output logic [ROWS-1:0] col_data,
  output logic            collide,
  output logic [6:0]      score,
  output logic            pending
);

  // state   | meaning
  // EMPTY   | nothing captured, gap satisfied
  // HELD    | a pipe waits in hold for its slot
  // GAPPING | a pipe was just injected, empty columns still owed
  typedef enum logic [1:0] {EMPTY, HELD, GAPPING} state_t;

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_V = GW'(GAP);

  state_t          state, state_n;
  logic [ROWS-1:0] field [COLS];
  logic [ROWS-1:0] hold, hold_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [ROWS-1:0] inject;
  logic            scroll, pat_v, hit, bird_oob, bird_bit, score_inc;

  assign scroll    = tick && !game_over;
  assign pat_v     = (pattern_in != '0) && !game_over;
  assign bird_oob  = (32'(bird_row) >= ROWS);
  // Shifting a one past the top bit yields zero, so out-of-range rows never index.
  assign bird_bit  = |(field[BIRD_COL] & (ROWS'(1) << bird_row));
  assign hit       = bird_oob || bird_bit;
  assign score_inc = (field[BIRD_COL] != '0) && !collide && (score < 7'd99);
  assign pending   = (state == HELD);
  assign col_data  = (32'(col_sel) < COLS) ? field[col_sel] : '0;

  always_comb begin
    state_n = state;
    hold_n  = hold;
    gap_n   = gap_cnt;
    inject  = '0;
    case (state)
      EMPTY: begin
        if (pat_v) begin
          hold_n  = pattern_in;
          state_n = HELD;
        end
      end
      HELD: begin
        if (scroll) begin
          if (gap_cnt == '0) begin
            inject = hold;
            hold_n = '0;
            gap_n  = GAP_V;
            if (GAP == 0) state_n = EMPTY;
            else          state_n = GAPPING;
          end else begin
            gap_n = gap_cnt - 1'b1;
          end
        end
      end
      GAPPING: begin
        if (scroll && gap_cnt != '0) gap_n = gap_cnt - 1'b1;
        if (pat_v) begin
          hold_n  = pattern_in;
          state_n = HELD;
        end else if (gap_n == '0) begin
          state_n = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      hold    <= '0;
      gap_cnt <= '0;
      collide <= 1'b0;
      score   <= '0;
      for (int i = 0; i < COLS; i++) field[i] <= '0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      gap_cnt <= gap_n;
      if (!game_over) begin
        collide <= collide | hit;
        if (scroll) begin
          for (int i = 0; i < COLS - 1; i++) field[i] <= field[i+1];
          field[COLS-1] <= inject;
          if (score_inc) score <= score + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: behavioural playfield model with per-cycle
// comparison, directed scenarios pinned by literal expectations, and random traffic.
module tb_pipe_field;

  localparam int ROWS = 15, COLS = 16, BIRD = 3, GAP = 3;

  logic            clk = 0, reset = 1, tick = 0, game_over = 0;
  logic [ROWS-1:0] pattern_in = '0;
  logic [3:0]      bird_row = 4'd10, col_sel = 4'd0;
  logic [ROWS-1:0] col_data;
  logic            collide, pending;
  logic [6:0]      score;

  pipe_field #(.ROWS(ROWS), .COLS(COLS), .BIRD_COL(BIRD), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .tick(tick), .game_over(game_over),
    .pattern_in(pattern_in), .bird_row(bird_row), .col_sel(col_sel),
    .col_data(col_data), .collide(collide), .score(score), .pending(pending));

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Model: a pipe waits until at least GAP empty columns followed the previous pipe.
  logic [ROWS-1:0] m_field [COLS];
  logic [ROWS-1:0] m_hold, m_inj;
  bit              m_held, m_coll, m_pre_held, m_hit;
  int              m_since, m_score;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) m_field[i] = '0;
      m_hold = '0; m_held = 0; m_coll = 0; m_score = 0; m_since = GAP;
    end else if (!game_over) begin
      m_hit = (bird_row >= ROWS) ? 1'b1 : m_field[BIRD][bird_row];
      m_pre_held = m_held;
      if (tick) begin
        if (m_field[BIRD] != 0 && !m_coll && m_score < 99) m_score++;
        if (m_pre_held && m_since >= GAP) begin
          m_inj = m_hold; m_held = 0; m_since = 0;
        end else begin
          m_inj = '0;
          if (m_since < 1000) m_since++;
        end
        for (int i = 0; i < COLS - 1; i++) m_field[i] = m_field[i+1];
        m_field[COLS-1] = m_inj;
      end
      if (!m_pre_held && pattern_in != 0) begin
        m_hold = pattern_in; m_held = 1;
      end
      m_coll = m_coll | m_hit;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_col_data", 32'(col_data), 32'(m_field[col_sel]));
      chk("model_collide", 32'(collide), 32'(m_coll));
      chk("model_score", 32'(score), 32'(m_score));
      chk("model_pending", 32'(pending), 32'(m_held));
    end
  end

  task automatic drive(input logic t, input logic [ROWS-1:0] p);
    tick = t; pattern_in = p;
    @(posedge clk); #1;
    tick = 0; pattern_in = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, '0);
  endtask

  task automatic do_reset();
    reset = 1; @(posedge clk); #1; reset = 0;
  endtask

  task automatic peek(input string name, input int col, input logic [ROWS-1:0] exp);
    col_sel = 4'(col); #1;
    chk(name, 32'(col_data), 32'(exp));
  endtask

  localparam logic [ROWS-1:0] P1 = 15'b110000011111111;
  localparam logic [ROWS-1:0] P2 = 15'h0011, P3 = 15'h0022, P4 = 15'h0044, P5 = 15'h0088;
  localparam logic [ROWS-1:0] C  = 15'b111100000111111;

  logic [ROWS-1:0] rp;

  initial begin
    @(posedge clk); #1;
    do_reset();
    cmp_en = 1;
    chk("reset_pending", 32'(pending), 0);
    chk("reset_score", 32'(score), 0);
    chk("reset_collide", 32'(collide), 0);
    peek("reset_col15", 15, '0);

    // capture then tick three cycles later
    drive(1'b0, P1);
    chk("capture_pending", 32'(pending), 1);
    drive(1'b0, '0); drive(1'b0, '0);
    drive(1'b1, '0);
    peek("capture_col15", 15, P1);
    chk("capture_pending_clr", 32'(pending), 0);

    // gap enforcement
    drive(1'b0, P2);
    ticks(3);
    chk("gap_pending_wait", 32'(pending), 1);
    ticks(1);
    peek("gap_col15", 15, P2);
    peek("gap_col14", 14, '0);
    peek("gap_col13", 13, '0);
    peek("gap_col12", 12, '0);
    peek("gap_col11", 11, P1);

    // drop in HELD and simultaneity in EMPTY
    drive(1'b0, P3);
    ticks(3);
    drive(1'b1, P4);
    peek("drop_col15", 15, P3);
    chk("drop_pending", 32'(pending), 0);
    ticks(3);
    drive(1'b1, P5);
    peek("simul_col15", 15, '0);
    chk("simul_pending", 32'(pending), 1);
    ticks(1);
    peek("simul_next_col15", 15, P5);

    // pipe passes clear of the bird
    do_reset();
    bird_row = 4'd8;
    drive(1'b0, C); ticks(1); ticks(COLS - 1 - BIRD);
    peek("pass_col3", BIRD, C);
    chk("pass_score_before", 32'(score), 0);
    ticks(1);
    chk("pass_score_after", 32'(score), 1);
    chk("pass_collide", 32'(collide), 0);

    // pipe hits the bird
    do_reset();
    bird_row = 4'd2;
    drive(1'b0, C); ticks(1); ticks(COLS - 1 - BIRD);
    chk("hit_collide_lag", 32'(collide), 0);
    drive(1'b0, '0);
    chk("hit_collide", 32'(collide), 1);
    ticks(1);
    chk("hit_score_frozen", 32'(score), 0);
    drive(1'b0, '0); drive(1'b0, '0);
    chk("hit_sticky", 32'(collide), 1);

    do_reset();
    bird_row = 4'd15;
    drive(1'b0, '0);
    chk("oob_collide", 32'(collide), 1);

    // game_over freeze
    do_reset();
    bird_row = 4'd8;
    drive(1'b0, C); ticks(2);
    drive(1'b0, P2);
    game_over = 1;
    ticks(5);
    drive(1'b0, P3); drive(1'b0, P4);
    chk("freeze_pending", 32'(pending), 1);
    peek("freeze_col14", 14, C);
    peek("freeze_col15", 15, '0);
    game_over = 0;
    ticks(3);
    peek("resume_col15", 15, P2);
    peek("resume_col11", 11, C);
    chk("resume_pending", 32'(pending), 0);

    // score saturation
    do_reset();
    bird_row = 4'd10;
    for (int n = 0; n < 101; n++) begin
      drive(1'b0, 15'($urandom_range(1, 127)));
      ticks(GAP + 1);
    end
    ticks(COLS);
    chk("sat_score", 32'(score), 99);
    chk("sat_collide", 32'(collide), 0);

    // reset during a tick
    drive(1'b0, P1);
    reset = 1; tick = 1; pattern_in = P2;
    @(posedge clk); #1;
    reset = 0; tick = 0; pattern_in = '0;
    chk("rst_score", 32'(score), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_collide", 32'(collide), 0);
    peek("rst_col15", 15, '0);

    // random traffic
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      bird_row = (seg == 1) ? 4'd5 : 4'($urandom_range(0, 14));
      for (int c = 0; c < 2000; c++) begin
        tick = ($urandom_range(0, 2) == 0);
        rp = ($urandom_range(0, 5) == 0) ? 15'($urandom) : '0;
        if (seg == 1) rp = rp & ~(15'd1 << 5);
        pattern_in = rp;
        game_over = ($urandom_range(0, 19) == 0);
        if (seg != 1 && $urandom_range(0, 63) == 0) bird_row = 4'($urandom_range(0, 15));
        col_sel = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
      end
      tick = 0; pattern_in = '0; game_over = 0;
    end

    drive(1'b0, '0);
    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
